// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// Optional feature macro used by the top: SCORE_HIGH_SCORE_EN.
package score_pkg;

  // Game-control state; the encoding is exported on run_state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  // One BCD digit.
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Next value of a single BCD digit on increment (9 wraps to 0).
  function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
    bcd_digit_t r;
    if (d == BCD_MAX) r = '0;
    else              r = d + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the score: synchronous clear, increment-in, carry-out.
// carry_out is combinational so a whole chain ripples within one cycle.
module bcd_digit_cell
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc_in,
  output logic [3:0] value,
  output logic       carry_out
);

  bcd_digit_t value_q, value_d;

  // Next digit value: clear has priority over increment.
  always_comb begin
    value_d = value_q;
    if (clear)       value_d = '0;
    else if (inc_in) value_d = bcd_next(value_q);
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc_in && (value_q == BCD_MAX);

endmodule

// File: rtl/score_bcd_counter.sv
// Running game score as NUM_DIGITS BCD digits with a one-digit read port.
// Optional high-score register enabled by defining SCORE_HIGH_SCORE_EN.
//
// Read handshake: rd_req is sampled at a clock edge together with rd_idx
// (and rd_sel_hi); exactly one edge later rd_valid is 1 for one cycle and
// digit_out carries the digit as it was held before the request edge.
// There is no back-pressure; a request may be issued every cycle. Without a
// request rd_valid is 0 and digit_out keeps its last value.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 12,
  parameter int IDX_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               game_over,
  input  logic               score_tick,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_sel_hi,
  output logic               rd_valid,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               saturated,
  output logic [1:0]         run_state
);

  state_e     state_q, state_d;
  bcd_digit_t score_digits [NUM_DIGITS];
  bcd_digit_t rd_src       [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;
  logic       clear;
  logic       all_nines;
  logic       tick_ok;
  logic       top_carry_unused;
  logic       rd_valid_q, rd_valid_d;
  bcd_digit_t digit_q, digit_d;
  bcd_digit_t rd_digit;

  // Entering RUN (from any state) clears the score; start always wins.
  assign clear = start;

  // Controller state: start -> RUN from anywhere, game_over only leaves RUN.
  always_comb begin
    state_d = state_q;
    if (start)                             state_d = RUN;
    else if (game_over && state_q == RUN)  state_d = FROZEN;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Detect the all-9s score; holding there is the saturation condition.
  always_comb begin
    all_nines = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (score_digits[k] != BCD_MAX) all_nines = 1'b0;
    end
  end

  // A tick counts only in RUN, not on a restart edge, and not once saturated.
  assign tick_ok  = (state_q == RUN) && score_tick && !start && !all_nines;
  assign carry[0] = tick_ok;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .inc_in    (carry[k]),
      .value     (score_digits[k]),
      .carry_out (carry[k+1])
    );
  end

  // Overflow out of the top digit cannot happen because ticks stop at all-9s.
  assign top_carry_unused = carry[NUM_DIGITS];

`ifdef SCORE_HIGH_SCORE_EN
  bcd_digit_t hi_q [NUM_DIGITS];
  bcd_digit_t hi_d [NUM_DIGITS];
  logic       score_gt_hi;

  // BCD magnitude compare: more significant digits are visited later and
  // override any decision made by less significant ones.
  always_comb begin
    score_gt_hi = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (score_digits[k] > hi_q[k])      score_gt_hi = 1'b1;
      else if (score_digits[k] < hi_q[k]) score_gt_hi = 1'b0;
    end
  end

  // Capture a better score on the RUN -> FROZEN edge only.
  always_comb begin
    hi_d = hi_q;
    if (state_q == RUN && game_over && !start && score_gt_hi) hi_d = score_digits;
  end

  // High-score register; survives start, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) hi_q[k] <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  // Read source follows rd_sel_hi.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      rd_src[k] = rd_sel_hi ? hi_q[k] : score_digits[k];
    end
  end
`else
  logic sel_hi_unused;
  assign sel_hi_unused = rd_sel_hi;

  // Without high-score storage every read returns the current score.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      rd_src[k] = score_digits[k];
    end
  end
`endif

  // Digit mux; an index past the last digit yields 0.
  always_comb begin
    rd_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_digit = rd_src[k];
    end
  end

  // Read pipeline next-state: valid mirrors the request, data holds otherwise.
  always_comb begin
    rd_valid_d = rd_req;
    digit_d    = digit_q;
    if (rd_req) digit_d = rd_digit;
  end

  // Read pipeline registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      digit_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      digit_q    <= digit_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign digit_out = DIGIT_W'(digit_q);
  assign saturated = all_nines;
  assign run_state = state_q;

endmodule
